// File: rtl/ps2_key_sequencer_if.sv
// rtl/ps2_key_sequencer_if.sv - decoded key event handshake between the sequencer and its consumer
`timescale 1ns/1ps
interface ps2_key_sequencer_if;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic [3:0] digit;
    logic       is_digit;

    modport master (
        output key_valid, key_code, key_break, key_ext, digit, is_digit,
        input  key_ready
    );
    modport slave (
        input  key_valid, key_code, key_break, key_ext, digit, is_digit,
        output key_ready
    );
endinterface

// File: rtl/ps2_key_sequencer.sv
// rtl/ps2_key_sequencer.sv - PS/2 frame receiver, E0/F0 prefix folding and key event FIFO
// Optional keypad digit decode is built when PS2_DIGIT_MAP_EN is defined.
`timescale 1ns/1ps
module ps2_key_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET,
    input  logic                   PS2_CLK,
    input  logic                   PS2_DAT,
    ps2_key_sequencer_if.master    key,
    output logic                   frame_err,
    output logic                   overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_prev_q;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [9:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic fall, dat, byte_ok, err, push, pop, push_ok, full, valid;
    logic [9:0] head;

    assign fall  = clk_prev_q & ~clk_sync_q[1];
    assign dat   = dat_sync_q[1];
    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign valid = (count_q != '0);
    assign pop   = valid & key.key_ready;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_cnt_d  = '0;
        byte_ok   = 1'b0;
        err       = 1'b0;
        // Watchdog runs only inside a frame and restarts on every keyboard clock edge
        if (state_q != IDLE && !fall) begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                err     = 1'b1;
                state_d = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
        if (fall) begin
            case (state_q)
                IDLE: if (!dat) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    shift_d   = {dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat;
                    state_d = STOP;
                end
                STOP: begin
                    if (dat && (^shift_q ^ par_q)) byte_ok = 1'b1;
                    else                           err     = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        push  = 1'b0;
        if (err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_ok) begin
            if (shift_q == 8'hE0)      ext_d = 1'b1;
            else if (shift_q == 8'hF0) brk_d = 1'b1;
            else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
        frame_err_d = err;
    end

    always_comb begin
        // A full FIFO still accepts a push when the head leaves in the same cycle
        push_ok    = push & (~full | pop);
        overflow_d = overflow_q | (push & full & ~pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = {ext_q, brk_q, shift_q};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            clk_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q  <= {dat_sync_q[0], PS2_DAT};
            clk_prev_q  <= clk_sync_q[1];
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign frame_err     = frame_err_q;
    assign overflow      = overflow_q;
    assign key.key_valid = valid;
    assign key.key_code  = valid ? head[7:0] : 8'h00;
    assign key.key_break = valid & head[8];
    assign key.key_ext   = valid & head[9];

`ifdef PS2_DIGIT_MAP_EN
    always_comb begin
        key.digit    = 4'd0;
        key.is_digit = 1'b0;
        if (valid && !head[9]) begin
            key.is_digit = 1'b1;
            case (head[7:0])
                8'h70:   key.digit = 4'd0;
                8'h69:   key.digit = 4'd1;
                8'h72:   key.digit = 4'd2;
                8'h7A:   key.digit = 4'd3;
                8'h6B:   key.digit = 4'd4;
                8'h73:   key.digit = 4'd5;
                8'h74:   key.digit = 4'd6;
                8'h6C:   key.digit = 4'd7;
                8'h75:   key.digit = 4'd8;
                8'h7D:   key.digit = 4'd9;
                default: key.is_digit = 1'b0;
            endcase
        end
    end
`else
    assign key.digit    = 4'd0;
    assign key.is_digit = 1'b0;
`endif
endmodule

// File: doc/ps2_key_sequencer.md
# ps2_key_sequencer

Sequences the PS/2 keyboard datapath on the system clock. It synchronizes the raw PS/2 lines and validates each 11-bit frame (start, 8 data bits, odd parity, stop). It folds the E0/F0 prefix bytes into single key events and buffers those events in a small FIFO behind a valid/ready handshake. Downstream calculator logic consumes one decoded key event per handshake instead of raw scan-code bytes.

## Interface
Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 50000: CLOCK_50 cycles without a PS2_CLK falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- PS2_CLK  in  1  raw keyboard clock, asynchronous.
- PS2_DAT  in  1  raw keyboard data, asynchronous.
- key_valid  out  1  FIFO head holds an event.
- key_ready  in  1  consumer accepts head event this cycle.
- key_code  out  8  head event scan code.
- key_break  out  1  head event is a release (F0-prefixed).
- key_ext  out  1  head event is extended (E0-prefixed).
- digit  out  4  decimal value of head key, 0–9.
- is_digit  out  1  head key is a non-extended keypad digit.
- frame_err  out  1  one-cycle pulse on a parity, stop or timeout error.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- Synchronization: 2-flop synchronizers on PS2_CLK and PS2_DAT. A falling edge is the previous sync value 1 and the current value 0. Data is sampled in the edge cycle.
- Frame FSM states and transitions:
  - IDLE: on an edge with DAT=0 → DATA, bit count 0. An edge with DAT=1 is ignored and the FSM stays in IDLE.
  - DATA: shift bits in LSB first; after 8 bits → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: DAT must be 1 and the XOR of the 8 data bits and parity must be 1. If both hold, the byte is good; otherwise pulse frame_err. Either way → IDLE.
- Timeout: in any state other than IDLE, a counter reloads on each edge. Reaching TIMEOUT_CYCLES pulses frame_err, returns the FSM to IDLE and clears the prefix flags.
- Byte sequencer:
  - Good byte E0 sets the ext flag.
  - Good byte F0 sets the brk flag.
  - Any other good byte pushes {ext, brk, code} into the FIFO, then clears both flags.
  - Any frame error clears both flags.
- FIFO:
  - Push when not full. A push while full is dropped and sets overflow; overflow clears only on RESET.
  - key_valid = not empty. A pop occurs when key_valid && key_ready.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Push into an empty FIFO with key_ready=1: the event is presented first and popped no earlier than the next cycle.
- Digit decode (combinational from head, only when key_ext=0): 70→0, 69→1, 72→2, 7A→3, 6B→4, 73→5, 74→6, 6C→7, 75→8, 7D→9. For all other codes, digit=0 and is_digit=0.
- Output values while key_valid=0: key_code, key_break, key_ext, digit and is_digit are all 0.
- Reset mid-frame: the partial frame, prefix flags, FIFO contents and timeout counter are all discarded.

## Timing
- Reset values: key_valid 0, key_code 0, key_break 0, key_ext 0, digit 0, is_digit 0, frame_err 0, overflow 0. After reset the FSM is in IDLE.
- Edge detect latency: 3 CLOCK_50 edges from the raw PS2_CLK fall (2 sync + 1 edge register).
- Event latency: key_valid rises on the CLOCK_50 edge after the stop-bit edge cycle.
- frame_err is asserted on that same edge for exactly 1 cycle.
- The head is stable while key_valid=1 and key_ready=0.
- After a pop, the next entry, if any, appears on the following edge.
- PS2_CLK is 10–16.7 kHz and CLOCK_50 is ≥1000× faster; no edge is missed.

## Configuration
- PS2_DIGIT_MAP_EN defined: the digit and is_digit decode is built as described above.
- PS2_DIGIT_MAP_EN undefined: digit is tied to 4'd0 and is_digit to 0, and no decode logic is generated. All other behaviour is identical.

## Test plan
- Frame 0x73 (parity 0, stop 1), key_ready=1 → one event: code 73, brk 0, ext 0, digit 5, is_digit 1, frame_err never set.
- Frames F0 then 73 → single event: code 73, brk 1, ext 0; no event produced for F0.
- Frames E0 then 75 → event: code 75, ext 1, brk 0, is_digit 0, digit 0.
- Frame 0x73 with parity bit 1 → frame_err high 1 cycle, no event. Following good frame 0x69 → event 69, digit 1.
- Start bit + 4 data bits, then PS2_CLK idle high for more than TIMEOUT_CYCLES → frame_err pulse, FSM in IDLE. Next frame 0x70 → event 70, digit 0.
- key_ready=0, five frames 70, 69, 72, 7A, 6B with FIFO_DEPTH=4 → overflow=1. Raising key_ready drains 70, 69, 72, 7A in order, then key_valid=0. RESET clears overflow.
